// File: rtl/sram_boot_loader.sv
// Streams a byte image little-endian into 64-bit SRAM words, optionally zero-fills the rest, then releases the core.
// One cycle per byte plus one per word written; input is held off (in_ready=0) while a word is being written or cleared.
module sram_boot_loader #(
   parameter int DP       = 16384,
   parameter int AW       = 14,
   parameter bit CLEAR_EN = 1'b1
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          sram_wen,
   output logic [AW-1:0] sram_addr,
   output logic [63:0]   sram_wdata,
   output logic [7:0]    sram_wstrb,
   output logic          core_rstn,
   output logic          done,
   output logic          overflow
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FILL  = 3'd1;
   localparam logic [2:0] WRITE = 3'd2;
   localparam logic [2:0] CLEAR = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

   logic [2:0]    state;
   logic [AW-1:0] word_cnt;
   logic [2:0]    byte_idx;
   logic [63:0]   wbuf;
   logic          last_seen;
   logic          at_end;
   logic          acc;

   assign at_end = (word_cnt == LAST_ADDR);
   assign acc    = in_valid && in_ready;

   // Outputs decode the registered state only, so in_ready never depends on in_valid.
   assign in_ready   = (state == FILL) || (state == DRAIN);
   assign sram_wen   = (state == WRITE) || (state == CLEAR);
   assign sram_addr  = word_cnt;
   assign sram_wdata = (state == WRITE) ? wbuf : 64'd0;
   assign sram_wstrb = sram_wen ? 8'hFF : 8'h00;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         word_cnt  <= '0;
         byte_idx  <= 3'd0;
         wbuf      <= 64'd0;
         last_seen <= 1'b0;
         core_rstn <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= FILL;
            end
            FILL: begin
               if (acc) begin
                  wbuf[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx <= byte_idx + 3'd1;
                  if (byte_idx == 3'd7 || in_last) begin
                     state     <= WRITE;
                     last_seen <= in_last;
                  end
               end
            end
            WRITE: begin
               // Buffer is cleared here so a short final word carries zeros in its unused lanes.
               word_cnt <= word_cnt + 1'b1;
               byte_idx <= 3'd0;
               wbuf     <= 64'd0;
               if (last_seen) begin
                  state <= (CLEAR_EN && !at_end) ? CLEAR : DONE;
               end else if (!at_end) begin
                  state <= FILL;
               end else begin
                  state    <= DRAIN;
                  overflow <= 1'b1;
               end
            end
            CLEAR: begin
               word_cnt <= word_cnt + 1'b1;
               if (at_end) state <= DONE;
            end
            DRAIN: begin
               if (acc && in_last) state <= DONE;
            end
            DONE: begin
               done      <= 1'b1;
               core_rstn <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_boot_loader.sv
// Three loader configurations driven one at a time; expected SRAM writes queued per image, checked as writes appear.
module tb_sram_boot_loader;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rstn  [3];
   logic        start [3];
   logic        vld   [3];
   logic [7:0]  dat   [3];
   logic        lst   [3];
   logic        rdy   [3];
   logic        wen   [3];
   logic [63:0] wdata [3];
   logic [7:0]  wstrb [3];
   logic        done  [3];
   logic        crst  [3];
   logic        ovf   [3];
   logic [3:0]  a0;
   logic [1:0]  a1;
   logic [0:0]  a2;
   int unsigned addr  [3];

   assign addr[0] = 32'(a0);
   assign addr[1] = 32'(a1);
   assign addr[2] = 32'(a2);

   int dp_of  [3] = '{16, 4, 2};
   bit clr_of [3] = '{1'b0, 1'b1, 1'b1};

   sram_boot_loader #(.DP(16), .AW(4), .CLEAR_EN(1'b0)) u0 (
      .CLK(CLK), .RSTn(rstn[0]), .start(start[0]), .in_valid(vld[0]), .in_data(dat[0]),
      .in_last(lst[0]), .in_ready(rdy[0]), .sram_wen(wen[0]), .sram_addr(a0),
      .sram_wdata(wdata[0]), .sram_wstrb(wstrb[0]), .core_rstn(crst[0]), .done(done[0]),
      .overflow(ovf[0]));

   sram_boot_loader #(.DP(4), .AW(2), .CLEAR_EN(1'b1)) u1 (
      .CLK(CLK), .RSTn(rstn[1]), .start(start[1]), .in_valid(vld[1]), .in_data(dat[1]),
      .in_last(lst[1]), .in_ready(rdy[1]), .sram_wen(wen[1]), .sram_addr(a1),
      .sram_wdata(wdata[1]), .sram_wstrb(wstrb[1]), .core_rstn(crst[1]), .done(done[1]),
      .overflow(ovf[1]));

   sram_boot_loader #(.DP(2), .AW(1), .CLEAR_EN(1'b1)) u2 (
      .CLK(CLK), .RSTn(rstn[2]), .start(start[2]), .in_valid(vld[2]), .in_data(dat[2]),
      .in_last(lst[2]), .in_ready(rdy[2]), .sram_wen(wen[2]), .sram_addr(a2),
      .sram_wdata(wdata[2]), .sram_wstrb(wstrb[2]), .core_rstn(crst[2]), .done(done[2]),
      .overflow(ovf[2]));

   typedef struct {
      int          inst;
      int unsigned addr;
      logic [63:0] data;
      bit          consec;
   } wr_t;

   wr_t sbq[$];
   int  last_wr [3];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc   = 0;

   always @(posedge CLK) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every SRAM write from any instance must match the head of the expectation queue.
   always @(negedge CLK) begin
      wr_t e;
      for (int i = 0; i < 3; i++) begin
         if (wen[i] === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("spurious_wen", 64'(wen[i]), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("wr_inst", 64'(i), 64'(e.inst));
               chk("wr_addr", 64'(addr[i]), 64'(e.addr));
               chk("wr_data", wdata[i], e.data);
               chk("wr_strb", 64'(wstrb[i]), 64'h0FF);
               if (e.consec) chk("clr_consec", 64'(cyc), 64'(last_wr[i] + 1));
            end
            last_wr[i] = cyc;
         end
      end
   end

   task automatic chk_idle(input int i, input string tag);
      chk({tag, "_rdy"},   64'(rdy[i]),   64'd0);
      chk({tag, "_wen"},   64'(wen[i]),   64'd0);
      chk({tag, "_addr"},  64'(addr[i]),  64'd0);
      chk({tag, "_wdata"}, wdata[i],      64'd0);
      chk({tag, "_wstrb"}, 64'(wstrb[i]), 64'd0);
      chk({tag, "_done"},  64'(done[i]),  64'd0);
      chk({tag, "_crst"},  64'(crst[i]),  64'd0);
      chk({tag, "_ovf"},   64'(ovf[i]),   64'd0);
   endtask

   task automatic do_reset(input int i);
      rstn[i] = 1'b0;
      start[i] = 1'b0; vld[i] = 1'b0; dat[i] = 8'd0; lst[i] = 1'b0;
      repeat (2) @(posedge CLK);
      #1 rstn[i] = 1'b1;
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1;
      @(posedge CLK);
      #1 start[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [7:0] d, input bit l, input bit gap);
      bit r = 1'b0;
      int t = 0;
      vld[i] = 1'b1; dat[i] = d; lst[i] = l;
      while (!r && t < 50) begin
         @(negedge CLK);
         r = rdy[i];
         @(posedge CLK);
         #1;
         t++;
      end
      if (!r) chk("accept_timeout", 64'(r), 64'd1);
      vld[i] = 1'b0; lst[i] = 1'b0;
      if (gap) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic run_image(input int i, input logic [7:0] img[$], input bit gap, input int start_mid);
      int n  = img.size();
      int dp = dp_of[i];
      int nw = (n + 7) / 8;
      int nwr;
      int c0;
      int t  = 0;
      bit ov = (n > dp * 8);
      wr_t e;
      if (nw > dp) nw = dp;
      nwr = nw;
      for (int w = 0; w < nw; w++) begin
         e.inst = i; e.addr = w; e.data = 64'd0; e.consec = 1'b0;
         for (int b = 0; b < 8; b++)
            if (w * 8 + b < n) e.data[8*b +: 8] = img[w * 8 + b];
         sbq.push_back(e);
      end
      if (clr_of[i] && !ov) begin
         for (int a = nw; a < dp; a++) begin
            e.inst = i; e.addr = a; e.data = 64'd0; e.consec = 1'b1;
            sbq.push_back(e);
            nwr++;
         end
      end
      pulse_start(i);
      c0 = cyc;
      for (int k = 0; k < n; k++) begin
         if (k == start_mid) start[i] = 1'b1;
         send(i, img[k], k == n - 1, gap);
         start[i] = 1'b0;
      end
      while (done[i] !== 1'b1 && t < 200) begin
         @(negedge CLK);
         t++;
      end
      chk("done",      64'(done[i]), 64'd1);
      chk("core_rstn", 64'(crst[i]), 64'd1);
      chk("overflow",  64'(ovf[i]),  64'(ov));
      if (!gap) chk("latency", 64'(cyc - c0), 64'(n + nwr + 1));
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   initial begin
      logic [7:0] img[$];
      for (int i = 0; i < 3; i++) begin
         rstn[i] = 1'b0; start[i] = 1'b0; vld[i] = 1'b0; dat[i] = 8'd0; lst[i] = 1'b0;
         last_wr[i] = 0;
      end
      repeat (3) @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) chk_idle(i, "por");
      for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
      @(posedge CLK);
      #1;

      // 16 bytes into DP=16, no clear; start re-pulsed while filling must be ignored
      img = {};
      for (int k = 0; k < 16; k++) img.push_back(8'(k));
      run_image(0, img, 1'b0, 3);

      // start while done: nothing may change
      pulse_start(0);
      repeat (3) @(posedge CLK);
      #1;
      chk("done_hold", 64'(done[0]), 64'd1);
      chk("crst_hold", 64'(crst[0]), 64'd1);
      chk("rdy_done",  64'(rdy[0]),  64'd0);
      chk("ovf_done",  64'(ovf[0]),  64'd0);

      // partial word followed by zero fill of the rest of a 4-word SRAM
      img = {8'hAA, 8'hBB, 8'hCC};
      run_image(1, img, 1'b0, -1);

      // oversized image into DP=2: two writes, remaining 4 bytes drained
      img = {};
      for (int k = 0; k < 20; k++) img.push_back(8'(8'h40 + k));
      run_image(2, img, 1'b0, -1);

      // image of exactly DP*8 bytes is not an overflow
      do_reset(2);
      img = {};
      for (int k = 0; k < 16; k++) img.push_back(8'($urandom));
      run_image(2, img, 1'b0, -1);

      // valid toggling, last on byte 0 of the second word
      do_reset(0);
      img = {};
      for (int k = 0; k < 9; k++) img.push_back(8'($urandom));
      run_image(0, img, 1'b1, -1);

      // reset mid-fill: outputs clear at once, no writes until the next start
      do_reset(0);
      pulse_start(0);
      for (int k = 0; k < 5; k++) send(0, 8'(8'h10 + k), 1'b0, 1'b0);
      #2 rstn[0] = 1'b0;
      #1 chk_idle(0, "mid_rst");
      @(posedge CLK);
      #1 rstn[0] = 1'b1;
      vld[0] = 1'b1; dat[0] = 8'h5A; lst[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         chk("rdy_after_rst", 64'(rdy[0]), 64'd0);
      end
      @(posedge CLK);
      #1 vld[0] = 1'b0; lst[0] = 1'b0;
      img = {};
      for (int k = 0; k < 8; k++) img.push_back(8'(8'hF0 + k));
      run_image(0, img, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
